// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the instruction ROM into the IR, and applies decode redirects.
// Optional FETCH_CNT_EN adds a fetch_cnt output counting consumed instructions.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jmp_valid,
    input  logic [25:0] jmp_target,
`ifdef FETCH_CNT_EN
    output logic [31:0] fetch_cnt,
`endif
    output logic        halted
);

    localparam logic [31:0] WIN_END = 32'(ROM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        fire, redirect, active, take, in_window;
    logic [31:0] pc_plus4, br_target, jmp_addr, target;

    assign rom_addr  = pc;
    assign fire      = ir_valid & ir_ready;
    assign redirect  = fire & (br_taken | jmp_valid);
    assign pc_plus4  = ir_pc + 32'd4;
    assign br_target = pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign jmp_addr  = {pc_plus4[31:28], jmp_target, 2'b00};
    assign target    = jmp_valid ? jmp_addr : br_target;
    // The start edge itself already fetches, so the first word appears one edge after start.
    assign active    = (state == RUN) | ((state == IDLE) & start);
    assign take      = active & (!ir_valid | fire);
    assign in_window = pc < WIN_END;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= 32'h0;
            ir_pc    <= 32'h0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            halted <= !redirect & (state == DONE) & !ir_valid;
            if (redirect) begin
                pc       <= target;
                ir_valid <= 1'b0;
                state    <= RUN;
            end else if (!stall || state == IDLE) begin
                if (state == IDLE && start)
                    state <= RUN;
                if (take) begin
                    if (in_window) begin
                        ir       <= rom_inst;
                        ir_pc    <= pc;
                        pc       <= pc + 32'd4;
                        ir_valid <= 1'b1;
                    end else begin
                        ir_valid <= 1'b0;
                        state    <= DONE;
                    end
                end else if (state == DONE && fire) begin
                    ir_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_CNT_EN
    // A redirecting fire may coincide with stall; it still consumes an instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_cnt <= 32'h0;
        else if (fire && (redirect || !stall))
            fetch_cnt <= fetch_cnt + 32'd1;
    end
`endif

endmodule
